// File: rtl/seq_unpacker.sv
// Serialises one packet of up to PACKET_SIZE sequences into one sequence per cycle.
// Define SEQ_UNPACKER_OVERLAP_TRIM_EN to trim bytes already covered by the previous job's last match.
module seq_unpacker #(
   parameter int PACKET_SIZE = 4,
   parameter int LL_BITS     = 17,
   parameter int ML_BITS     = 17,
   parameter int OFFSET_BITS = 17
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_valid,
   input  logic [PACKET_SIZE-1:0]             i_mask,
   input  logic [LL_BITS*PACKET_SIZE-1:0]     i_ll,
   input  logic [ML_BITS*PACKET_SIZE-1:0]     i_ml,
   input  logic [OFFSET_BITS*PACKET_SIZE-1:0] i_offset,
   input  logic [ML_BITS-1:0]                 i_overlap,
   input  logic                               i_eoj,
   input  logic                               i_delim,
   output logic                               i_ready,
   output logic                               o_valid,
   output logic [LL_BITS-1:0]                 o_ll,
   output logic [ML_BITS-1:0]                 o_ml,
   output logic [OFFSET_BITS-1:0]             o_offset,
   output logic                               o_eoj,
   output logic                               o_delim,
   input  logic                               o_ready
);

   localparam int IDX_W = $clog2(PACKET_SIZE);

   logic [PACKET_SIZE-1:0]             r_pend;
   logic [LL_BITS*PACKET_SIZE-1:0]     r_ll;
   logic [ML_BITS*PACKET_SIZE-1:0]     r_ml;
   logic [OFFSET_BITS*PACKET_SIZE-1:0] r_off;
   logic                               r_eoj;
   logic                               r_delim;

   logic [IDX_W-1:0]       w_cur;
   logic                   w_any;
   logic                   w_last;
   logic [LL_BITS-1:0]     w_cur_ll;
   logic [ML_BITS-1:0]     w_cur_ml;
   logic [OFFSET_BITS-1:0] w_cur_off;
   logic                   w_eoj_flag;
   logic                   w_delim_flag;
   logic [LL_BITS-1:0]     w_out_ll;
   logic [ML_BITS-1:0]     w_out_ml;
   logic                   w_drop;
   logic                   w_consume;
   logic                   w_accept;

   // Lowest pending slot wins; scanning downward lets the lowest overwrite.
   always_comb begin
      w_cur = '0;
      for (int k = PACKET_SIZE - 1; k >= 0; k--) begin
         if (r_pend[k]) w_cur = IDX_W'(k);
      end
   end

   // Bits only clear from the bottom, so a single remaining bit is the packet's highest slot.
   assign w_any        = |r_pend;
   assign w_last       = w_any && ((r_pend & (r_pend - PACKET_SIZE'(1))) == '0);
   assign w_cur_ll     = r_ll[w_cur*LL_BITS +: LL_BITS];
   assign w_cur_ml     = r_ml[w_cur*ML_BITS +: ML_BITS];
   assign w_cur_off    = r_off[w_cur*OFFSET_BITS +: OFFSET_BITS];
   assign w_eoj_flag   = r_eoj & w_last;
   assign w_delim_flag = r_delim & w_last;

`ifdef SEQ_UNPACKER_OVERLAP_TRIM_EN
   localparam int SW = ((LL_BITS > ML_BITS) ? LL_BITS : ML_BITS) + 1;

   logic [ML_BITS-1:0] r_carry;
   logic [ML_BITS-1:0] r_overlap;
   logic [SW-1:0]      w_cext;
   logic [SW-1:0]      w_llext;
   logic [SW-1:0]      w_sum;
   logic [SW-1:0]      w_c;
   logic [SW-1:0]      w_lt;

   // Carry eats literals first, then the match; the sum is one bit wider so it never wraps.
   assign w_cext   = SW'(r_carry);
   assign w_llext  = SW'(w_cur_ll);
   assign w_sum    = w_llext + SW'(w_cur_ml);
   assign w_c      = (w_cext < w_sum) ? w_cext : w_sum;
   assign w_lt     = (w_cext < w_llext) ? w_cext : w_llext;
   assign w_out_ll = w_cur_ll - LL_BITS'(w_lt);
   assign w_out_ml = w_cur_ml - ML_BITS'(w_c - w_lt);
   assign w_drop   = w_any && (w_out_ll == '0) && (w_out_ml == '0) && !w_eoj_flag && !w_delim_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry   <= '0;
         r_overlap <= '0;
      end else begin
         if (w_consume) begin
            r_carry <= (w_last && r_eoj) ? r_overlap : (r_carry - ML_BITS'(w_c));
         end
         // An empty end-of-job packet arrives after any old entry leaves, so it wins.
         if (w_accept) begin
            r_overlap <= i_overlap;
            if ((i_mask == '0) && i_eoj) r_carry <= i_overlap;
         end
      end
   end
`else
   logic w_unused_overlap;

   assign w_unused_overlap = ^i_overlap;
   assign w_out_ll         = w_cur_ll;
   assign w_out_ml         = w_cur_ml;
   assign w_drop           = 1'b0;
`endif

   assign w_consume = w_any && (w_drop || o_ready);
   assign i_ready   = !w_any || (w_last && (w_drop || o_ready));
   assign w_accept  = i_valid && i_ready;

   assign o_valid  = w_any && !w_drop;
   assign o_ll     = w_any ? w_out_ll : '0;
   assign o_ml     = w_any ? w_out_ml : '0;
   assign o_offset = w_any ? w_cur_off : '0;
   assign o_eoj    = w_eoj_flag;
   assign o_delim  = w_delim_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= '0;
         r_ll    <= '0;
         r_ml    <= '0;
         r_off   <= '0;
         r_eoj   <= 1'b0;
         r_delim <= 1'b0;
      end else begin
         if (w_consume) r_pend[w_cur] <= 1'b0;
         // Accept only happens when the hold is empty or its last entry leaves now.
         if (w_accept) begin
            r_pend  <= i_mask;
            r_ll    <= i_ll;
            r_ml    <= i_ml;
            r_off   <= i_offset;
            r_eoj   <= i_eoj;
            r_delim <= i_delim;
         end
      end
   end

endmodule
